// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream and program-memory bus between the loader and
// its neighbours.
//   rx_data/rx_valid : byte from the serial receiver, no backpressure
//   ram_addr/ram_wdata/ram_we : program-memory address, write data, write strobe
//   ram_rdata        : program-memory read data, combinational from ram_addr
// The master modport is the loader side. The slave modport is the receiver and
// memory side.
interface prog_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  rx_data, rx_valid, ram_rdata,
    output ram_addr, ram_wdata, ram_we
  );

  modport slave (
    output rx_data, rx_valid, ram_rdata,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a program image as a byte stream and writes it into
// program memory. It then hands the memory to the CPU.
// The stream is a 16-bit word count N, then N 16-bit words. Every field is
// sent low byte first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse that begins or restarts a load from any state
//   cpu_addr   : CPU fetch address, used in RUN
//   instr      : fetched instruction in RUN, 0 (NOP) otherwise
//   cpu_en     : CPU clock enable, high only in RUN once the last write is done
//   busy, err  : load in progress, load failed (bad header or timeout)
//   word_cnt   : words written in the current load
//   bus        : receiver byte input and program-memory port
//
// state   | meaning
// IDLE    | after reset, waiting for start
// HDR_LO  | waiting for the low byte of N
// HDR_HI  | waiting for the high byte of N; N is range-checked here
// LD_LO   | waiting for the low byte of the next word
// LD_HI   | waiting for the high byte; the write goes out in the next cycle
// RUN     | image loaded; the CPU owns the memory address
// ERROR   | bad header or inter-byte timeout; held until start or reset
module prog_loader #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_en,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt,
  prog_loader_if.master     bus
);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_LD_LO, S_LD_HI, S_RUN, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       hdr_q;
  logic [7:0]        lo_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              wr_pend_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              accept;
  logic [16:0]       hdr_full;
  logic [16:0]       cnt_inc;

  assign busy     = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                    (state_q == S_LD_LO)  || (state_q == S_LD_HI);
  // When start is asserted, a byte arriving in the same cycle is dropped.
  assign accept   = busy && bus.rx_valid && !start;
  assign hdr_full = {1'b0, bus.rx_data, hdr_q[7:0]};
  // The previous write has already committed before the next high byte can
  // arrive, so cnt_q is current here.
  assign cnt_inc  = 17'(cnt_q) + 17'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_LO: if (accept) state_d = S_HDR_HI;
      S_HDR_HI: if (accept) state_d = (hdr_full == 17'd0 || hdr_full > MAX_N) ? S_ERROR : S_LD_LO;
      S_LD_LO:  if (accept) state_d = S_LD_HI;
      S_LD_HI:  if (accept) state_d = (cnt_inc == {1'b0, hdr_q}) ? S_RUN : S_LD_LO;
      default:  ;
    endcase
    // tmo_q is a down-counter. It is reloaded on every accepted byte, and the
    // load fails when a busy cycle with no byte sees it at zero.
    if (busy && !accept && tmo_q == '0) state_d = S_ERROR;
    if (start) state_d = S_HDR_LO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hdr_q     <= '0;
      lo_q      <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_pend_q <= 1'b0;
      if (start) begin
        wptr_q <= '0;
        cnt_q  <= '0;
        tmo_q  <= TMO_LOAD;
      end else begin
        if (wr_pend_q) begin
          wptr_q <= wptr_q + 1'b1;
          cnt_q  <= cnt_q + 1'b1;
        end
        if (accept) begin
          tmo_q <= TMO_LOAD;
          case (state_q)
            S_HDR_LO: hdr_q[7:0]  <= bus.rx_data;
            S_HDR_HI: hdr_q[15:8] <= bus.rx_data;
            S_LD_LO:  lo_q        <= bus.rx_data;
            S_LD_HI: begin
              wr_pend_q <= 1'b1;
              wr_data_q <= DATA_W'({bus.rx_data, lo_q});
            end
            default: ;
          endcase
        end else if (busy && tmo_q != '0) begin
          tmo_q <= tmo_q - 1'b1;
        end
      end
    end
  end

  // The final write takes place in the first RUN cycle. The CPU gets the
  // address and the clock enable only after that write.
  assign err           = (state_q == S_ERROR);
  assign cpu_en        = (state_q == S_RUN) && !wr_pend_q;
  assign bus.ram_we    = wr_pend_q;
  assign bus.ram_wdata = wr_data_q;
  assign bus.ram_addr  = cpu_en ? cpu_addr : wptr_q;
  assign instr         = cpu_en ? bus.ram_rdata : '0;
  assign word_cnt      = cnt_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives random and directed load streams into prog_loader.
// A behavioural model tracks the stream position, the expected memory image
// and the load status. The outputs are compared with the model on every
// falling clock edge.
module tb_prog_loader;
  localparam int AW  = 11;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          start    = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] instr;
  logic          cpu_en, busy, err;
  logic [AW:0]   word_cnt;

  prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_addr(cpu_addr),
    .instr(instr), .cpu_en(cpu_en), .busy(busy), .err(err),
    .word_cnt(word_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  // program memory and write log
  logic [DW-1:0] tb_mem [0:2047] = '{default: '0};
  int            n_writes = 0;
  int            wlog_addr [0:1023];
  logic [DW-1:0] wlog_data [0:1023];
  assign bus.ram_rdata = tb_mem[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      tb_mem[bus.ram_addr]       <= bus.ram_wdata;
      wlog_addr[n_writes % 1024] <= int'(bus.ram_addr);
      wlog_data[n_writes % 1024] <= bus.ram_wdata;
      n_writes                   <= n_writes + 1;
    end
  end

  // behavioural model: mode 0 idle, 1 loading, 2 loaded, 3 failed
  int            m_mode, m_bytes, m_n, m_words, m_pend, m_pend_addr, m_idle;
  logic [7:0]    m_lo, m_nlo;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_mem [0:2047] = '{default: '0};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit c_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_bytes = 0; m_n = 0; m_words = 0; m_pend = 0;
    m_pend_addr = 0; m_idle = 0; m_lo = '0; m_nlo = '0; m_pend_data = '0;
  endtask

  task automatic model_step();
    if (m_pend != 0) begin
      m_mem[m_pend_addr] = m_pend_data;
      m_words++;
      m_pend = 0;
    end
    if (start) begin
      m_mode = 1; m_bytes = 0; m_words = 0; m_idle = 0;
    end else if (m_mode == 1) begin
      if (bus.rx_valid) begin
        int w;
        m_idle = 0;
        if (m_bytes == 0) m_nlo = bus.rx_data;
        else if (m_bytes == 1) begin
          m_n = int'({bus.rx_data, m_nlo});
          if (m_n == 0 || m_n > (1 << AW)) m_mode = 3;
        end else if (m_bytes % 2 == 0) m_lo = bus.rx_data;
        else begin
          w = (m_bytes - 3) / 2;
          m_pend = 1; m_pend_addr = w; m_pend_data = {bus.rx_data, m_lo};
          if (w + 1 == m_n) m_mode = 2;
        end
        m_bytes++;
      end else begin
        m_idle++;
        if (m_idle == TMO) m_mode = 3;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    bus.rx_valid = 1'b1; bus.rx_data = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
  endtask

  task automatic do_start(input bit with_byte);
    start = 1'b1;
    if (with_byte) begin bus.rx_valid = 1'b1; bus.rx_data = 8'($urandom); end
    tick();
    start = 1'b0; bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        c_en = (m_mode == 2) && (m_pend == 0);
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("err", 32'(err), 32'(m_mode == 3));
        chk("cpu_en", 32'(cpu_en), 32'(c_en));
        chk("ram_we", 32'(bus.ram_we), 32'(m_pend != 0));
        chk("word_cnt", 32'(word_cnt), 32'(m_words));
        if (m_pend != 0) begin
          chk("wr_addr", 32'(bus.ram_addr), 32'(m_pend_addr));
          chk("wr_data", 32'(bus.ram_wdata), 32'(m_pend_data));
        end else begin
          chk("ram_addr", 32'(bus.ram_addr), c_en ? 32'(cpu_addr) : 32'(m_words % 2048));
        end
        chk("instr", 32'(instr), c_en ? 32'(m_mem[cpu_addr]) : 32'd0);
        if (!rst_n) chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
      end
    end
  end

  initial begin
    int w0, r, n;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    #1 rst_n = 1'b0; model_reset(); chk_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cpu_en", 32'(cpu_en), 32'd0);
    chk("reset_instr", 32'(instr), 32'd0);
    tick(); rst_n = 1'b1; tick();

    // two-word load with gaps
    w0 = n_writes;
    do_start(1'b0);
    send_byte(8'h02, 2); send_byte(8'h00, 1);
    send_word(16'h1234, 2); send_word(16'h5678, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("load_cnt", 32'(word_cnt), 32'd2);
    chk("load_cpu_en", 32'(cpu_en), 32'd1);
    chk("load_nwr", 32'(n_writes - w0), 32'd2);
    chk("load_w0_addr", 32'(wlog_addr[w0 % 1024]), 32'd0);
    chk("load_w0_data", 32'(wlog_data[w0 % 1024]), 32'h1234);
    chk("load_w1_addr", 32'(wlog_addr[(w0 + 1) % 1024]), 32'd1);
    chk("load_w1_data", 32'(wlog_data[(w0 + 1) % 1024]), 32'h5678);

    // fetch in RUN, then restart
    tick(); cpu_addr = 11'd1;
    @(negedge clk);
    chk("run_addr", 32'(bus.ram_addr), 32'd1);
    chk("run_instr", 32'(instr), 32'h5678);
    tick(); do_start(1'b0);
    @(negedge clk);
    chk("restart_cpu_en", 32'(cpu_en), 32'd0);
    chk("restart_instr", 32'(instr), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    // same stream, back to back
    tick();
    w0 = n_writes;
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(16'h1234, 0); send_word(16'h5678, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("b2b_nwr", 32'(n_writes - w0), 32'd2);
    chk("b2b_w0_data", 32'(wlog_data[w0 % 1024]), 32'h1234);
    chk("b2b_w1_addr", 32'(wlog_addr[(w0 + 1) % 1024]), 32'd1);
    chk("b2b_w1_data", 32'(wlog_data[(w0 + 1) % 1024]), 32'h5678);
    chk("b2b_cpu_en", 32'(cpu_en), 32'd1);

    // bad headers
    tick(); w0 = n_writes;
    do_start(1'b0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    repeat (2) tick();
    @(negedge clk);
    chk("hdr0_err", 32'(err), 32'd1);
    chk("hdr0_cpu_en", 32'(cpu_en), 32'd0);
    chk("hdr0_nwr", 32'(n_writes - w0), 32'd0);
    tick();
    do_start(1'b0); send_byte(8'h01, 0); send_byte(8'h08, 0);
    repeat (2) tick();
    @(negedge clk);
    chk("hdr2049_err", 32'(err), 32'd1);
    chk("hdr2049_nwr", 32'(n_writes - w0), 32'd0);

    // timeout after one byte of the first word
    tick();
    do_start(1'b0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
    repeat (15) tick();
    @(negedge clk);
    chk("tmo_15_err", 32'(err), 32'd0);
    tick();
    @(negedge clk);
    chk("tmo_16_err", 32'(err), 32'd1);
    chk("tmo_cnt", 32'(word_cnt), 32'd0);

    // reset mid-load, then a full reload from address 0
    tick();
    do_start(1'b0); send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_word(16'ha1b2, 0); send_byte(8'hc3, 0);
    tick();
    rst_n = 1'b0; model_reset();
    @(negedge clk);
    chk("arst_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("arst_addr", 32'(bus.ram_addr), 32'd0);
    chk("arst_cnt", 32'(word_cnt), 32'd0);
    tick(); rst_n = 1'b1; tick();
    w0 = n_writes;
    do_start(1'b0); send_byte(8'h03, 1); send_byte(8'h00, 0);
    send_word(16'h1111, 0); send_word(16'h2222, 1); send_word(16'h3333, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("reload_w0_addr", 32'(wlog_addr[w0 % 1024]), 32'd0);
    chk("reload_w0_data", 32'(wlog_data[w0 % 1024]), 32'h1111);
    chk("reload_w2_addr", 32'(wlog_addr[(w0 + 2) % 1024]), 32'd2);
    chk("reload_cnt", 32'(word_cnt), 32'd3);

    // randomized loads
    for (int it = 0; it < 80; it++) begin
      tick();
      r = $urandom_range(0, 9);
      do_start(r == 1);
      if (r == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          send_byte(8'h00, 0); send_byte(8'h00, 1);
        end else begin
          send_byte(8'($urandom), 0); send_byte(8'($urandom_range(9, 255)), 0);
        end
      end else begin
        n = $urandom_range(1, 6);
        send_byte(n[7:0], $urandom_range(0, 3)); send_byte(8'h00, $urandom_range(0, 3));
        for (int k = 0; k < n; k++) begin
          if (r == 2 && k == 1) repeat (TMO + 2) tick();
          if (r == 3 && k == n - 1 && n > 1) break;
          if (r == 4 && k == 1) do_reset();
          send_word(16'($urandom), $urandom_range(0, 3));
        end
      end
      repeat ($urandom_range(2, 8)) begin
        cpu_addr = 11'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) begin bus.rx_valid = 1'b1; bus.rx_data = 8'($urandom); end
        tick();
        bus.rx_valid = 1'b0;
      end
    end

    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
